// File: rtl/regfile_sweep_clr.sv
// 2-read/1-write register file with optional zero register and write bypass.
// After reset or a clear request the entries are zeroed one per cycle; `ready` stays low meanwhile.
module regfile_sweep_clr #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [WIDTH-1:0]  WD3,
    input  logic              WE3,
    input  logic              clr_req,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              ready,
    output logic              wr_err
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One spare bit keeps the pointer from wrapping when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    state_t             state_r;
    logic [ADDR_W:0]    clr_ptr_r;
    logic               ready_r;
    logic               wr_err_r;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               wr_addr_ok_s;
    logic               wr_go_s;
    logic               fwd1_s;
    logic               fwd2_s;
    logic [WIDTH-1:0]   rd1_s;
    logic [WIDTH-1:0]   rd2_s;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_V);
    endfunction

    function automatic logic [WIDTH-1:0] read_mux(
        input logic              running,
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              fwd,
        input logic [WIDTH-1:0]  fwd_data
    );
        logic [WIDTH-1:0] val;
        if (!running) begin
            val = '0;
        end else if (!addr_in_range(addr)) begin
            val = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end else if (fwd) begin
            val = fwd_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Write qualification: legal address, file running, no clear request competing.
    always_comb begin
        wr_addr_ok_s = addr_in_range(A3) && !((ZERO_REG != 0) && (A3 == '0));
        wr_go_s      = WE3 && ready_r && !clr_req && wr_addr_ok_s;
        fwd1_s       = (BYPASS != 0) && wr_go_s && (A3 == A1);
        fwd2_s       = (BYPASS != 0) && wr_go_s && (A3 == A2);
    end

    // Read ports.
    always_comb begin
        rd1_s = read_mux(ready_r, A1, mem[A1], fwd1_s, WD3);
        rd2_s = read_mux(ready_r, A2, mem[A2], fwd2_s, WD3);
    end

    assign RD1    = rd1_s;
    assign RD2    = rd2_s;
    assign ready  = ready_r;
    assign wr_err = wr_err_r;

    // Sweep/run controller with sticky dropped-write flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
            ready_r   <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (WE3) begin
                        wr_err_r <= 1'b1;
                    end
                    if (clr_ptr_r == LAST_PTR) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                    clr_ptr_r <= clr_ptr_r + (ADDR_W+1)'(1);
                end
                ST_RUN: begin
                    if (clr_req) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= '0;
                        ready_r   <= 1'b0;
                        if (WE3) begin
                            wr_err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= '0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep zeroing in CLEAR, qualified writes in RUN.
    always_ff @(posedge clk) begin
        if (rst && (state_r == ST_CLEAR)) begin
            mem[clr_ptr_r[ADDR_W-1:0]] <= '0;
        end else if (rst && wr_go_s) begin
            mem[A3] <= WD3;
        end
    end

endmodule

// File: tb/tb_regfile_sweep_clr.sv
// Directed bench: a default instance plus a DEPTH=24, no-zero-register, no-bypass instance
// sharing the same stimulus.
module tb_regfile_sweep_clr;

    logic        clk;
    logic        rst;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic        we3;
    logic        clr_req;
    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        ready, wr_err, nb_ready, nb_wr_err;

    int n_vec = 0;
    int n_err = 0;

    regfile_sweep_clr dut (
        .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
        .clr_req(clr_req), .RD1(rd1), .RD2(rd2), .ready(ready), .wr_err(wr_err)
    );

    regfile_sweep_clr #(.DEPTH(24), .ZERO_REG(0), .BYPASS(0)) nb (
        .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
        .clr_req(clr_req), .RD1(nb_rd1), .RD2(nb_rd2), .ready(nb_ready), .wr_err(nb_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] enb;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts cycles with ready low, starting just after the edge that entered CLEAR.
    task automatic sweep_count(input string name, input logic pulse_clr);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            if (pulse_clr) clr_req = (n == 3);
            if (n == 2) begin
                a1 = 5'd5;
                #1;
                chk({name, "_rd_in_clear"}, rd1, 32'h0);
            end
            n++;
            @(negedge clk);
            #1;
        end
        clr_req = 1'b0;
        chk({name, "_len"}, 32'(n), 32'd32);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 5'd5,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 5'd7,  5'd5,  5'd7,  32'h00001234, 32'h00001234, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b0, 5'd7,  5'd0,  5'd0,  32'h0,        32'h00001234, 32'h0,        32'h00001234};
        tbl[4]  = '{1'b1, 5'd0,  5'd7,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h00001234, 32'h0};
        tbl[5]  = '{1'b0, 5'd0,  5'd5,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'hFFFFFFFF};
        tbl[6]  = '{1'b1, 5'd5,  5'd7,  5'd5,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00001234, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 5'd5,  5'd5,  5'd0,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[8]  = '{1'b1, 5'd31, 5'd30, 5'd31, 32'h00000031, 32'h00000031, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 5'd31, 5'd31, 5'd0,  32'h0,        32'h00000031, 32'h00000031, 32'h0};
        tbl[10] = '{1'b1, 5'd23, 5'd31, 5'd23, 32'h00000023, 32'h00000023, 32'h00000031, 32'h0};
        tbl[11] = '{1'b0, 5'd23, 5'd0,  5'd0,  32'h0,        32'h00000023, 32'h0,        32'h00000023};

        rst = 1'b0; we3 = 1'b0; clr_req = 1'b0;
        a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; wd3 = 32'h0;

        // Power-up reset and first sweep.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        rst = 1'b1;
        sweep_count("sweep_rst", 1'b0);
        chk("sweep_done_rd1", rd1, 32'h0);

        // Write/read, bypass, zero register, address boundaries.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we3 = tbl[i].we; a1 = tbl[i].a1; a2 = tbl[i].a2; a3 = tbl[i].a3; wd3 = tbl[i].wd;
            #1;
            chk($sformatf("v%0d_rd1", i), rd1, tbl[i].e1);
            chk($sformatf("v%0d_rd2", i), rd2, tbl[i].e2);
            chk($sformatf("v%0d_nb_rd1", i), nb_rd1, tbl[i].enb);
            chk($sformatf("v%0d_ready", i), 32'({ready, nb_ready}), 32'd3);
            chk($sformatf("v%0d_wr_err", i), 32'(wr_err), 32'd0);
        end
        @(negedge clk);
        we3 = 1'b0; a2 = 5'd0;
        #1;
        chk("nb_zero_entry", nb_rd2, 32'hFFFFFFFF);

        // Clear request colliding with a write; clear requests during CLEAR are ignored.
        a1 = 5'd3; a3 = 5'd3; wd3 = 32'h0000CAFE; we3 = 1'b1; clr_req = 1'b1;
        #1;
        chk("coll_no_bypass", rd1, 32'h0);
        @(negedge clk);
        we3 = 1'b0; clr_req = 1'b0;
        #1;
        chk("coll_ready", 32'(ready), 32'd0);
        chk("coll_wr_err", 32'(wr_err), 32'd1);
        chk("coll_nb_wr_err", 32'(nb_wr_err), 32'd1);
        sweep_count("sweep_clr", 1'b1);
        a1 = 5'd3; a2 = 5'd5;
        #1;
        chk("coll_rd_a3", rd1, 32'h0);
        chk("coll_rd_old5", rd2, 32'h0);
        chk("coll_wr_err_sticky", 32'(wr_err), 32'd1);

        // Reset in the middle of a sweep restarts it from entry 0.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst2_wr_err", 32'(wr_err), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        we3 = 1'b1;
        @(negedge clk);
        we3 = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("clear_we_err", 32'(wr_err), 32'd1);
        chk("mid_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst3_wr_err", 32'(wr_err), 32'd0);
        rst = 1'b1;
        sweep_count("sweep_mid_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
